// File: rtl/calc_sequencer_if.sv
// Key-event and display bundle between the keypad decoder, the calculator
// sequencer and the display driver.
interface calc_sequencer_if #(
  parameter int WIDTH = 14
);
  logic             btn_press;
  logic             is_num;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic [WIDTH-1:0] disp_mag;
  logic             disp_neg;
  logic             err;
  logic [2:0]       state;
  logic             key_ack;

  modport master (
    output btn_press, is_num, is_op, is_eq, num_val, op_val,
    input  disp_mag, disp_neg, err, state, key_ack
  );

  modport slave (
    input  btn_press, is_num, is_op, is_eq, num_val, op_val,
    output disp_mag, disp_neg, err, state, key_ack
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds decimal operands from key events, applies +,-(,*)
// and drives a sign-magnitude display value. Define CALC_MUL_EN to enable multiply.
module calc_sequencer #(
  parameter int WIDTH      = 14,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  calc_sequencer_if.slave  bus
);

`ifdef CALC_MUL_EN
  localparam int EW = 2*WIDTH + 2;
`else
  localparam int EW = WIDTH + 2;
`endif
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic signed [EW-1:0] LIM = EW'(10**MAX_DIGITS - 1);

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_OP  = 3'd1,
    S_B   = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } state_t;

  typedef logic signed [WIDTH:0]  val_t;
  typedef logic signed [EW-1:0]   ext_t;

  state_t           state_q, state_d;
  val_t             a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             press_q;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             neg_q, neg_d, err_q, err_d, ack_q, ack_d;

  function automatic ext_t ext(input val_t v);
    return {{(EW-WIDTH-1){v[WIDTH]}}, v};
  endfunction

  function automatic logic fits(input ext_t v);
    return (v <= LIM) && (v >= -LIM);
  endfunction

  function automatic val_t append(input val_t x, input logic [3:0] d);
    return (x <<< 3) + (x <<< 1) + val_t'({{(WIDTH-3){1'b0}}, d});
  endfunction

  function automatic logic [WIDTH-1:0] mag_of(input val_t v);
    return WIDTH'(v[WIDTH] ? -v : v);
  endfunction

  logic evt, one_hot, op_legal, num_ok, op_ok, eq_ok, room;
  val_t dig;
  ext_t res;

  assign evt      = bus.btn_press & ~press_q;
  assign one_hot  = ({bus.is_num, bus.is_op, bus.is_eq} == 3'b100) ||
                    ({bus.is_num, bus.is_op, bus.is_eq} == 3'b010) ||
                    ({bus.is_num, bus.is_op, bus.is_eq} == 3'b001);
`ifdef CALC_MUL_EN
  assign op_legal = (bus.op_val != 2'd0);
`else
  assign op_legal = (bus.op_val == 2'd1) || (bus.op_val == 2'd2);
`endif
  assign num_ok   = evt & one_hot & bus.is_num & (bus.num_val <= 4'd9);
  assign op_ok    = evt & one_hot & bus.is_op & op_legal;
  assign eq_ok    = evt & one_hot & bus.is_eq;
  assign room     = (cnt_q < CW'(MAX_DIGITS));
  assign dig      = val_t'({{(WIDTH-3){1'b0}}, bus.num_val});

  // Full-precision result of the latched operation on A and B
  always_comb begin
    res = '0;
    case (op_q)
      2'd1:    res = ext(a_q) + ext(b_q);
      2'd2:    res = ext(a_q) - ext(b_q);
`ifdef CALC_MUL_EN
      2'd3:    res = ext(a_q) * ext(b_q);
`endif
      default: res = '0;
    endcase
  end

  always_comb begin
    val_t show;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ack_d   = 1'b0;
    case (state_q)
      S_A: begin
        if (num_ok && room) begin
          a_d   = append(a_q, bus.num_val);
          cnt_d = cnt_q + CW'(1);
          ack_d = 1'b1;
        end else if (op_ok) begin
          op_d    = bus.op_val;
          state_d = S_OP;
          ack_d   = 1'b1;
        end
      end
      S_OP: begin
        if (num_ok) begin
          b_d     = dig;
          cnt_d   = CW'(1);
          state_d = S_B;
          ack_d   = 1'b1;
        end else if (op_ok) begin
          op_d  = bus.op_val;
          ack_d = 1'b1;
        end
      end
      S_B: begin
        if (num_ok && room) begin
          b_d   = append(b_q, bus.num_val);
          cnt_d = cnt_q + CW'(1);
          ack_d = 1'b1;
        end else if (op_ok || eq_ok) begin
          ack_d = 1'b1;
          if (!fits(res)) begin
            state_d = S_ERR;
          end else if (eq_ok) begin
            r_d     = val_t'(res);
            state_d = S_RES;
          end else begin
            // Chaining: the result becomes the next left operand
            r_d     = val_t'(res);
            a_d     = val_t'(res);
            op_d    = bus.op_val;
            cnt_d   = '0;
            state_d = S_OP;
          end
        end
      end
      S_RES: begin
        if (num_ok) begin
          a_d     = dig;
          cnt_d   = CW'(1);
          state_d = S_A;
          ack_d   = 1'b1;
        end else if (op_ok) begin
          a_d     = r_q;
          op_d    = bus.op_val;
          state_d = S_OP;
          ack_d   = 1'b1;
        end
      end
      S_ERR: begin
        if (num_ok) begin
          a_d     = dig;
          cnt_d   = CW'(1);
          state_d = S_A;
          ack_d   = 1'b1;
        end
      end
      default: state_d = S_A;
    endcase

    case (state_d)
      S_A, S_OP: show = a_d;
      S_B:       show = b_d;
      S_RES:     show = r_d;
      default:   show = '0;
    endcase
    mag_d = mag_of(show);
    neg_d = show[WIDTH];
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      press_q <= 1'b0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      press_q <= bus.btn_press;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.disp_mag = mag_q;
  assign bus.disp_neg = neg_q;
  assign bus.err      = err_q;
  assign bus.state    = state_q;
  assign bus.key_ack  = ack_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key sequences plus random key streams
// compared against an integer calculator model.
module tb_calc_sequencer;
  localparam int WIDTH = 14;
  localparam int LIM   = 9999;
`ifdef CALC_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  calc_sequencer #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int tot_acks = 0;

  // Calculator model: 0=entering A, 1=op pending, 2=entering B, 3=result, 4=error
  int m_state, m_a, m_b, m_r, m_cnt, m_op;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_r = 0; m_cnt = 0; m_op = 0;
  endtask

  function automatic int apply_op(input int a, input int op, input int b);
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a * b;
      default: return 0;
    endcase
  endfunction

  task automatic model_key(input bit n, input bit o, input bit e, input int nv,
                           input int ov, output int ack);
    int v;
    ack = 0;
    if (int'(n) + int'(o) + int'(e) != 1) return;
    if (n && nv > 9) return;
    if (o && (ov == 0 || (ov == 3 && !MUL))) return;
    case (m_state)
      0: if (n) begin
           if (m_cnt < 4) begin m_a = m_a * 10 + nv; m_cnt++; ack = 1; end
         end else if (o) begin
           m_op = ov; m_state = 1; ack = 1;
         end
      1: if (n) begin m_b = nv; m_cnt = 1; m_state = 2; ack = 1; end
         else if (o) begin m_op = ov; ack = 1; end
      2: if (n) begin
           if (m_cnt < 4) begin m_b = m_b * 10 + nv; m_cnt++; ack = 1; end
         end else begin
           ack = 1;
           v = apply_op(m_a, m_op, m_b);
           if (v > LIM || v < -LIM) m_state = 4;
           else if (e) begin m_r = v; m_state = 3; end
           else begin m_r = v; m_a = v; m_op = ov; m_cnt = 0; m_state = 1; end
         end
      3: if (n) begin m_a = nv; m_cnt = 1; m_state = 0; ack = 1; end
         else if (o) begin m_a = m_r; m_op = ov; m_state = 1; ack = 1; end
      default: if (n) begin m_a = nv; m_cnt = 1; m_state = 0; ack = 1; end
    endcase
  endtask

  function automatic int shown();
    case (m_state)
      0, 1: return m_a;
      2:    return m_b;
      3:    return m_r;
      default: return 0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    int v;
    v = shown();
    check({tag, ".mag"},   int'(bus.disp_mag), (v < 0) ? -v : v);
    check({tag, ".neg"},   int'(bus.disp_neg), int'(v < 0));
    check({tag, ".err"},   int'(bus.err),      int'(m_state == 4));
    check({tag, ".state"}, int'(bus.state),    m_state);
  endtask

  task automatic clear_keys();
    bus.btn_press = 1'b0; bus.is_num = 1'b0; bus.is_op = 1'b0; bus.is_eq = 1'b0;
    bus.num_val = 4'd0; bus.op_val = 2'd0;
  endtask

  task automatic press(input bit n, input bit o, input bit e, input int nv,
                       input int ov, input int hold, input int low);
    int acks, exp_ack;
    acks = 0;
    @(negedge clk);
    bus.is_num = n; bus.is_op = o; bus.is_eq = e;
    bus.num_val = 4'(nv); bus.op_val = 2'(ov);
    bus.btn_press = 1'b1;
    repeat (hold) begin @(negedge clk); acks += int'(bus.key_ack); end
    clear_keys();
    repeat (low) begin @(negedge clk); acks += int'(bus.key_ack); end
    model_key(n, o, e, nv, ov, exp_ack);
    tot_acks += acks;
    check("key_ack", acks, exp_ack);
    check_outputs("key");
  endtask

  task automatic num(input int d);  press(1, 0, 0, d, 0, 5, 3); endtask
  task automatic op(input int o);   press(0, 1, 0, 0, o, 5, 3); endtask
  task automatic eq();              press(0, 0, 1, 0, 0, 5, 3); endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    tot_acks = 0;
    @(negedge clk);
  endtask

  initial begin
    int r, acks;
    clear_keys();
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.mag",   int'(bus.disp_mag), 0);
    check("rst.neg",   int'(bus.disp_neg), 0);
    check("rst.err",   int'(bus.err),      0);
    check("rst.state", int'(bus.state),    0);
    check("rst.ack",   int'(bus.key_ack),  0);
    rst = 1'b1;
    @(negedge clk);

    // 12 + 34 = 46
    tot_acks = 0;
    num(1); num(2); op(1); num(3); num(4); eq();
    check("add.mag", int'(bus.disp_mag), 46);
    check("add.state", int'(bus.state), 3);
    check("add.acks", tot_acks, 6);

    // 5 - 9 = -4, then -4 + 2 = -2
    num(5); op(2); num(9); eq();
    check("sub.mag", int'(bus.disp_mag), 4);
    check("sub.neg", int'(bus.disp_neg), 1);
    op(1); num(2); eq();
    check("chain.mag", int'(bus.disp_mag), 2);
    check("chain.neg", int'(bus.disp_neg), 1);

    // Fifth digit is dropped
    do_reset();
    num(1); num(2); num(3); num(4); num(5);
    check("digits.mag", int'(bus.disp_mag), 1234);
    check("digits.acks", tot_acks, 4);

    // Overflow and recovery
    do_reset();
    num(9); num(9); num(9); num(9); op(1); num(1); eq();
    check("ovf.state", int'(bus.state), 4);
    check("ovf.err", int'(bus.err), 1);
    check("ovf.mag", int'(bus.disp_mag), 0);
    num(7);
    check("rec.state", int'(bus.state), 0);
    check("rec.mag", int'(bus.disp_mag), 7);
    check("rec.err", int'(bus.err), 0);

    // Multiply present or absent
    do_reset();
    num(1); num(2); op(3);
`ifdef CALC_MUL_EN
    num(1); num(2); eq();
    check("mul.mag", int'(bus.disp_mag), 144);
    do_reset();
    num(9); num(9); num(9); num(9); op(3); num(2); eq();
    check("mul.ovf", int'(bus.state), 4);
`else
    check("nomul.mag", int'(bus.disp_mag), 12);
    check("nomul.state", int'(bus.state), 0);
`endif

    // Long hold gives one event
    do_reset();
    tot_acks = 0;
    press(1, 0, 0, 3, 0, 40, 3);
    check("hold.acks", tot_acks, 1);

    // Async reset mid-entry clears outputs at once
    do_reset();
    num(1); num(2); op(1); num(5);
    check("mid.state", int'(bus.state), 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst.mag",   int'(bus.disp_mag), 0);
    check("arst.neg",   int'(bus.disp_neg), 0);
    check("arst.err",   int'(bus.err),      0);
    check("arst.state", int'(bus.state),    0);
    check("arst.ack",   int'(bus.key_ack),  0);
    model_reset();

    // Key held through reset release yields one event
    @(negedge clk);
    bus.is_num = 1'b1; bus.num_val = 4'd7; bus.btn_press = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (6) begin @(negedge clk); acks += int'(bus.key_ack); end
    clear_keys();
    repeat (2) begin @(negedge clk); acks += int'(bus.key_ack); end
    check("relhold.acks", acks, 1);
    check("relhold.mag", int'(bus.disp_mag), 7);
    m_a = 7; m_cnt = 1;

    // Random key stream, including malformed events
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      press(1, 0, 0, $urandom_range(0, 10), 0, $urandom_range(1, 6), $urandom_range(1, 3));
      else if (r <= 6) press(0, 1, 0, 0, $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(1, 3));
      else if (r <= 8) press(0, 0, 1, 0, 0, $urandom_range(1, 6), $urandom_range(1, 3));
      else             press(1, 1, $urandom_range(0, 1), $urandom_range(0, 9), 1, $urandom_range(1, 6), $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the FPGA calculator: consumes decoded key events from the keypad scanner (digit, operator, equals), builds two decimal operands, applies the selected operation and presents a sign-magnitude value for the display driver. It sits between the keypad decoder and the display and owns all calculator state: operands, pending operator, result and error.

## Interface
- WIDTH, 14: magnitude width of operands, result and display value; must hold 10^MAX_DIGITS-1.
- MAX_DIGITS, 4: maximum decimal digits per operand entry.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_press  in  1  high while a key is held (after scanner stretch).
- is_num  in  1  digit key flag; valid while btn_press=1.
- is_op  in  1  operator key flag.
- is_eq  in  1  equals key flag.
- num_val  in  4  digit value 0..9.
- op_val  in  2  1=add, 2=sub, 3=mul, 0=none.
- disp_mag  out  WIDTH  displayed magnitude.
- disp_neg  out  1  displayed value is negative.
- err  out  1  overflow/error indicator.
- state  out  3  FSM state encoding (debug).
- key_ack  out  1  one-cycle pulse: key event accepted.

## Operation
- Event: evt = btn_press & ~press_q (press_q = btn_press registered). One event per press regardless of hold length. Flags and values are sampled in the evt cycle.
- Malformed event (flags not one-hot, num_val>9, is_op with op_val=0): ignored, no key_ack.
- Operands A, B, result R held signed; legal range ±(10^MAX_DIGITS-1).
- Digit append: X = X*10 + d while digit count < MAX_DIGITS; further digits ignored (no key_ack).
- States (encoding): S_A=0, S_OP=1, S_B=2, S_RES=3, S_ERR=4.
- S_A (shows A): num → append to A. op → latch op, go S_OP. eq → ignored.
- S_OP (shows A): num → B=d, count=1, go S_B. op → replace latched op. eq → ignored.
- S_B (shows B): num → append to B. eq → R=A op B, go S_RES. op → R=A op B, A=R, latch new op, go S_OP (chaining).
- S_RES (shows R): num → A=d, count=1, go S_A. op → A=R, latch op, go S_OP. eq → ignored.
- S_ERR: disp_mag=0, disp_neg=0, err=1. num → A=d, go S_A; op/eq ignored.
- Arithmetic is full-precision signed; |R| > 10^MAX_DIGITS-1 → S_ERR instead of S_RES/S_OP.
- Display: sign-magnitude of the shown value; zero is never negative.
- key_ack pulses for every accepted event, including ones that end in S_ERR.

## Timing
- Reset (async assert, sync-safe release): state=S_A, A=B=R=0, counts=0, op=0, press_q=0; disp_mag=0, disp_neg=0, err=0, key_ack=0.
- All outputs registered; update one clk after the evt cycle.
- press_q resets to 0: a key held through reset release produces one event on the first cycle after release.
- Reset mid-entry or mid-chain discards all state; no partial result is kept.
- A new event requires btn_press to fall for at least one cycle.

## Configuration
- CALC_MUL_EN defined: op_val=3 is multiply, product checked against range, overflow → S_ERR.
- CALC_MUL_EN undefined: op_val=3 is malformed (ignored, no key_ack); no multiplier is synthesized.

## Test plan
- Keys 1,2,+,3,4,= (each press 5 cycles high, 3 low) → disp_mag=46, disp_neg=0, state=S_RES, six key_ack pulses.
- 5,-,9,= → disp_mag=4, disp_neg=1; then + , 2, = → disp_mag=2, disp_neg=1.
- Digits 1,2,3,4,5 in S_A → disp_mag=1234; fifth press gives no key_ack.
- 9,9,9,9,+,1,= → state=S_ERR, err=1, disp_mag=0; then 7 → state=S_A, disp_mag=7, err=0.
- CALC_MUL_EN: 1,2,op3,1,2,= → 144; 9,9,9,9,op3,2,= → S_ERR. Without macro: op3 ignored, display stays at 12.
- Hold key 3 for 40 cycles → exactly one key_ack; assert rst low mid-entry (A=12, S_B) → all outputs zero in the same cycle, state=S_A.
